// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared types and constants for the branch resolver slice.
//               pred_entry_t : one in-flight static prediction
//               br_state_e   : resolver operating state
//               PC_STEP      : fall-through increment for a not-taken branch
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

  typedef struct packed {
    logic        taken;
    logic [31:0] pc;
    logic [31:0] target;
  } pred_entry_t;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } br_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage
`default_nettype wire

// File: rtl/pred_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pred_fifo
// Description : DEPTH-entry synchronous FIFO of pred_entry_t with a
//               single-cycle clear. Head entry is visible combinationally.
// Ports       : clk, rst_i (async, active-high)
//               push/wdata  - write an entry (ignored when full)
//               pop         - drop the head entry (ignored when empty)
//               clear       - empty the FIFO; overrides push and pop
//               head        - oldest entry
//               count, full - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module pred_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  pred_entry_t            wdata,
  output pred_entry_t            head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int                  c_aw   = $clog2(DEPTH);
  localparam logic [c_aw:0]       c_full = (c_aw + 1)'(DEPTH);

  pred_entry_t     r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign full   = (r_count == c_full);
  assign w_push = push && !full;
  assign w_pop  = pop && (r_count != '0);
  assign head   = r_mem[r_rd_ptr];
  assign count  = r_count;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (w_push && !clear) r_mem[r_wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolver
// Description : Tracks in-flight fetch predictions and resolves them in
//               program order against execute outcomes. A mispredict flushes,
//               redirects fetch and then stalls fetch for RECOVER_CYCLES.
// Ports       : clk, rst_i (async, active-high)
//               pred_valid_i/pred_ready_o/pred_taken_i/pred_pc_i/pred_target_i
//               res_valid_i/res_taken_i/res_target_i
//               flush_o, redirect_pc_o, res_err_o, outstanding_o
//               stat_resolved_o, stat_mispred_o (BRANCH_STATS_EN only)
// Config      : `define BRANCH_STATS_EN to add saturating statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolver
  import branch_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   pred_valid_i,
  output logic                   pred_ready_o,
  input  logic                   pred_taken_i,
  input  logic [31:0]            pred_pc_i,
  input  logic [31:0]            pred_target_i,
  input  logic                   res_valid_i,
  input  logic                   res_taken_i,
  input  logic [31:0]            res_target_i,
  output logic                   flush_o,
  output logic [31:0]            redirect_pc_o,
  output logic                   res_err_o,
  output logic [$clog2(DEPTH):0] outstanding_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]            stat_resolved_o,
  output logic [31:0]            stat_mispred_o
`endif
);

  localparam int            c_rw   = $clog2(RECOVER_CYCLES) + 1;
  localparam logic [c_rw-1:0] c_rload = c_rw'(RECOVER_CYCLES - 1);

  br_state_e              r_state;
  logic [c_rw-1:0]        r_rcnt;

  pred_entry_t            w_head;
  pred_entry_t            w_wdata;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_push;
  logic                   w_res_active;
  logic                   w_pop;
  logic                   w_mispred;
  logic [31:0]            w_correct_pc;

  assign pred_ready_o = (r_state == RUN) && !w_full;
  assign w_push       = pred_valid_i && pred_ready_o;
  assign w_wdata      = '{taken: pred_taken_i, pc: pred_pc_i, target: pred_target_i};

  // Resolves are dropped during recovery; the reset term keeps the
  // combinational pulses at 0 while reset is asserted.
  assign w_res_active = res_valid_i && (r_state == RUN) && !rst_i;
  assign w_pop        = w_res_active && (w_count != '0);
  assign res_err_o    = w_res_active && (w_count == '0);

  assign w_mispred = w_pop &&
                     ((res_taken_i != w_head.taken) ||
                      (res_taken_i && w_head.taken && (res_target_i != w_head.target)));

  assign w_correct_pc  = res_taken_i ? res_target_i : (w_head.pc + PC_STEP);
  assign flush_o       = w_mispred;
  assign redirect_pc_o = w_mispred ? w_correct_pc : 32'd0;
  assign outstanding_o = w_count;

  pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_i (rst_i),
    .push  (w_push),
    .pop   (w_pop),
    .clear (w_mispred),
    .wdata (w_wdata),
    .head  (w_head),
    .count (w_count),
    .full  (w_full)
  );

  // Counter is loaded with RECOVER_CYCLES-1 and RECOVER is left after the
  // cycle where it reads 0, giving exactly RECOVER_CYCLES stalled cycles.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RUN;
      r_rcnt  <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mispred) begin
            r_state <= RECOVER;
            r_rcnt  <= c_rload;
          end
        end
        RECOVER: begin
          if (r_rcnt == '0) r_state <= RUN;
          else              r_rcnt  <= r_rcnt - 1'b1;
        end
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_resolved;
  logic [31:0] r_stat_mispred;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_stat_resolved <= '0;
      r_stat_mispred  <= '0;
    end else begin
      if (w_pop && (r_stat_resolved != 32'hFFFF_FFFF))
        r_stat_resolved <= r_stat_resolved + 32'd1;
      if (w_mispred && (r_stat_mispred != 32'hFFFF_FFFF))
        r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign stat_resolved_o = r_stat_resolved;
  assign stat_mispred_o  = r_stat_mispred;
`endif

endmodule
`default_nettype wire
